// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue.
// Contents: opcode and shift-field encodings, FSM state encoding, and the
// command bundle that travels through the command FIFO.
package alu_pkg;

    // Arithmetic opcodes: op[3]=0, op[2:1]=operand-B mode, op[0]=carry-in
    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDC = 4'b0011;
    localparam logic [3:0] OP_SUBB = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    // Logic opcodes: op[3]=1, op[0] is don't-care
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_NOT  = 4'b1110;

    localparam logic [1:0] SH_NONE  = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;
    localparam logic [1:0] SH_CLR   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Widest tag the command bundle can carry; narrower tags are zero-padded.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [3:0]           op;
        logic [1:0]           shift;
        logic [63:0]          a;
        logic [63:0]          b;
        logic [TAG_W_MAX-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issue queue.
// Ports: clk, rst_n (async active-low), push/push_data write side,
//        pop/pop_data read side (pop_data shows the head entry),
//        full, empty status.
// DEPTH must be a power of two, >= 2. Pushes when full and pops when empty
// are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the 64-bit combinational alu.
// Commands arrive on cmd_* (valid/ready), are queued in alu_cmd_fifo, decoded
// into registered alu_* selects/operands, and the alu sum/cout are captured
// and returned in order with the command tag on res_* (valid/ready).
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_shift/
//        cmd_a/cmd_b/cmd_tag; alu_a/alu_b/alu_s2..s0/alu_cin/alu_sel1/alu_sel0
//        to the alu; alu_sum/alu_cout from the alu; res_valid/res_ready/
//        res_sum/res_cout/res_tag; busy.
// Build option: define ALU_ISSUE_FLAGS_EN to add res_zero/res_neg outputs.
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head as soon as it is non-empty
// EXEC  | alu operands stable; result captured at the end of this cycle
// RESP  | result held on res_* until res_ready
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [1:0]        cmd_shift,
    input  logic [63:0]       cmd_a,
    input  logic [63:0]       cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [63:0]       alu_a,
    output logic [63:0]       alu_b,
    output logic              alu_s2,
    output logic              alu_s1,
    output logic              alu_s0,
    output logic              alu_cin,
    output logic              alu_sel1,
    output logic              alu_sel0,
    input  logic [63:0]       alu_sum,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_sum,
    output logic              res_cout,
    output logic [TAG_W-1:0]  res_tag,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic              res_zero,
    output logic              res_neg,
`endif
    output logic              busy
);

    logic [1:0]       state;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    alu_cmd_t         cmd_in;
    alu_cmd_t         cmd_head;
    logic [TAG_W-1:0] tag_q;
    logic             unused_tag;

    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = cmd_op;
        cmd_in.shift = cmd_shift;
        cmd_in.a     = cmd_a;
        cmd_in.b     = cmd_b;
        cmd_in.tag   = TAG_W_MAX'(cmd_tag);
    end

    // Gated with rst_n so every output reads 0 while reset is held.
    assign cmd_ready = rst_n & ~full;
    assign push      = cmd_valid & cmd_ready;

    // A new command is launched from IDLE, or straight from RESP when the
    // current result is being accepted, giving one result per two cycles.
    assign pop = ~empty & ((state == ST_IDLE) |
                           ((state == ST_RESP) & res_ready));

    assign busy = ~empty | (state != ST_IDLE);

    // Padding bits above TAG_W are always zero.
    assign unused_tag = |cmd_head.tag;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (cmd_head),
        .full      (full),
        .empty     (empty)
    );

    // Operand/select registers only change on a pop, so they are stable for
    // the whole EXEC cycle and hold their value through RESP and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s2   <= 1'b0;
            alu_s1   <= 1'b0;
            alu_s0   <= 1'b0;
            alu_cin  <= 1'b0;
            alu_sel1 <= 1'b0;
            alu_sel0 <= 1'b0;
            tag_q    <= '0;
        end else if (pop) begin
            alu_a    <= cmd_head.a;
            alu_b    <= cmd_head.b;
            alu_s2   <= cmd_head.op[3];
            alu_s1   <= cmd_head.op[2];
            alu_s0   <= cmd_head.op[1];
            alu_cin  <= cmd_head.op[0] & ~cmd_head.op[3];
            alu_sel1 <= cmd_head.shift[1];
            alu_sel0 <= cmd_head.shift[0];
            tag_q    <= cmd_head.tag[TAG_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_tag   <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_sum   <= alu_sum;
                    res_cout  <= alu_cout;
                    res_tag   <= tag_q;
                    res_valid <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                    res_zero  <= (alu_sum == '0);
                    res_neg   <= alu_sum[63];
`endif
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= empty ? ST_IDLE : ST_EXEC;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Command-buffering issue stage directly upstream of the 64-bit combinational alu.
- Accepts ALU commands (opcode, shift field, two operands, tag) over a valid/ready handshake and queues them in a small FIFO.
- Decodes each command into the alu select/carry lines and drives registered, stable operands.
- Captures alu sum/cout and returns them in order with the command tag over a second valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the command tag carried through to the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals not-full.
- cmd_op  in  4  opcode: [3]=logic select, [2:1]=operand-B mode, [0]=carry-in.
- cmd_shift  in  2  00 none, 01 left-by-1, 10 right-by-1, 11 clear.
- cmd_a  in  64  operand A.
- cmd_b  in  64  operand B.
- cmd_tag  in  TAG_W  command identifier.
- alu_a  out  64  registered operand A to alu.
- alu_b  out  64  registered operand B to alu.
- alu_s2, alu_s1, alu_s0  out  1 each  function selects.
- alu_cin  out  1  carry-in.
- alu_sel1, alu_sel0  out  1 each  shifter selects.
- alu_sum  in  64  alu result.
- alu_cout  in  1  alu carry/shift-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  64  captured result.
- res_cout  out  1  captured carry.
- res_tag  out  TAG_W  tag of the command that produced the result.
- busy  out  1  high when FIFO is non-empty or FSM is not IDLE.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM IDLE; cmd_ready=1 once out of reset.
- Decode, registered at pop:
  - alu_s2 = op[3]; alu_s1 = op[2]; alu_s0 = op[1].
  - alu_cin = op[0] & ~op[3]; carry-in is forced 0 for logic ops.
  - {alu_sel1, alu_sel0} = cmd_shift.
- Arithmetic opcodes (op[3]=0), B-mode 00/01/10/11 contributes 0 / B / ~B / all-ones, plus cin:
  - 0000 pass A, 0001 A+1
  - 0010 A+B, 0011 A+B+1
  - 0100 A+~B, 0101 A-B
  - 0110 A-1, 0111 pass A
- Logic opcodes (op[3]=1, op[0] ignored): 100x OR, 101x XOR, 110x AND, 111x NOT A.
- Shift field:
  - left: sum = result<<1, cout = pre-shift bit 63.
  - right: bit 63 = add carry, cout = 0.
  - clear: sum = 0, cout = 0.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop is FSM-controlled.
  - A push into an empty FIFO is not visible to a pop in the same cycle.
  - With full FIFO plus simultaneous pop, cmd_ready stays low that cycle; no bypass.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop and load alu_* registers and tag, go EXEC.
  - EXEC: alu settles from the stable registers; at the edge capture alu_sum/alu_cout into res_*, set res_valid, go RESP.
  - RESP: hold res_* stable while res_valid & ~res_ready. On res_ready: clear res_valid; if FIFO non-empty, pop and go EXEC, else go IDLE.
- Latency: accept at edge E0 -> operands driven after E1 -> res_valid high after E2.
- Throughput: one result per 2 cycles under res_ready=1.
- alu_* outputs hold their last value while IDLE and RESP; no glitching of operands during EXEC.
- Results are returned in command order.
- Reset asserted mid-operation: FIFO flushed, in-flight command dropped, res_valid cleared immediately (asynchronous).

Optional Feature:
- Macro ALU_ISSUE_FLAGS_EN.
- Defined: adds outputs res_zero (1 when captured sum == 0) and res_neg (captured sum bit 63). Both are registered with res_sum and reset to 0.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_PASS, OP_INC, OP_ADD, OP_ADDC, OP_SUBB, OP_SUB, OP_DEC, OP_OR, OP_XOR, OP_AND, OP_NOT)
  - shift localparams (SH_NONE, SH_LEFT, SH_RIGHT, SH_CLR)
  - FSM state encoding
  - command-bundle struct {op, shift, a, b, tag}
- Sub-module alu_cmd_fifo: parameterised DEPTH synchronous FIFO with full/empty; the FSM and decode stay in the top.

Test Plan:
- ADD: op=0010, shift=00, a=5, b=7, res_ready=1 -> res_sum=12, res_cout=0, res_valid 2 cycles after accept.
- SUB: op=0101, a=10, b=3 -> alu_cin=1, res_sum=7, res_cout=1. Also op=0101, a=3, b=10 -> res_sum=0xFFFF_FFFF_FFFF_FFF9, res_cout=0.
- Logic: op=1101 (AND with op[0]=1), a=0xF0F0, b=0xFF00 -> alu_cin=0, res_sum=0xF000.
- Shift: op=0000, a=0x8000_0000_0000_0001, shift=01 -> res_sum=0x2, res_cout=1. Same with shift=11 -> sum=0, cout=0.
- Backpressure: res_ready=0, push 6 commands with tags 0..5 -> cmd_ready drops after 5 accepted (DEPTH + 1 in flight). Release res_ready -> tags return in order 0..5, one per 2 cycles.
- Reset mid-operation: assert rst_n=0 during EXEC with 3 queued -> res_valid=0 and busy=0 immediately; after release, no stale results appear.
